// File: rtl/palette_ctrl.sv
// palette_ctrl - programmable 16 x RGB888 colour palette between the pixel
// generator and the HDMI encoder.
//
// Pixel path: two register stages, index -> RGB888, with de/hs/vs delayed to
// match. It never stalls and has a fixed latency of 2 cycles.
// Host path: a 1-entry write buffer with a two-state FSM (IDLE/PEND). A
// buffered write is committed to the table in a blanking cycle, or on the next
// cycle when COMMIT_IN_BLANK=0.
//
// Parameters
//   COMMIT_IN_BLANK  1: a pending write commits only in a cycle with pix_de=0
//   BLANK_RGB_ZERO   1: rgb is forced to 0 whenever rgb_de=0
// Optional build macro
//   PALETTE_READBACK_EN  adds rd_addr/rd_data, a registered table read port
//
// Ports
//   clk, rst_n                  pixel clock, async active-low reset
//   pix_index/de/hs/vs          incoming pixel index and timing
//   rgb, rgb_de/hs/vs           looked-up colour and timing, 2 cycles later
//   wr_valid/wr_ready           host write handshake
//   wr_addr, wr_data            palette entry and new RGB888 value
//   defaults_load               1-cycle pulse that restores the CGA palette
//   busy                        a write is pending (FSM in PEND)
//   rd_addr, rd_data            (PALETTE_READBACK_EN) table read, 1-cycle latency
`timescale 1ns/1ps
module palette_ctrl #(
  parameter bit COMMIT_IN_BLANK = 1'b1,
  parameter bit BLANK_RGB_ZERO  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  pix_index,
  input  logic        pix_de,
  input  logic        pix_hs,
  input  logic        pix_vs,
  output logic [23:0] rgb,
  output logic        rgb_de,
  output logic        rgb_hs,
  output logic        rgb_vs,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_addr,
  input  logic [23:0] wr_data,
  input  logic        defaults_load,
  output logic        busy
`ifdef PALETTE_READBACK_EN
  ,
  input  logic [3:0]  rd_addr,
  output logic [23:0] rd_data
`endif
);

  typedef struct packed {
    logic [3:0] idx;
    logic       de;
    logic       hs;
    logic       vs;
  } pix_t;

  typedef struct packed {
    logic [3:0]  addr;
    logic [23:0] data;
  } wr_req_t;

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  function automatic logic [23:0] cga_default(input logic [3:0] i);
    case (i)
      4'd0:  cga_default = 24'h000000;
      4'd1:  cga_default = 24'h0000AA;
      4'd2:  cga_default = 24'h00AA00;
      4'd3:  cga_default = 24'h00AAAA;
      4'd4:  cga_default = 24'hAA0000;
      4'd5:  cga_default = 24'hAA00AA;
      4'd6:  cga_default = 24'hAA5500;
      4'd7:  cga_default = 24'hAAAAAA;
      4'd8:  cga_default = 24'h555555;
      4'd9:  cga_default = 24'h5555FF;
      4'd10: cga_default = 24'h55FF55;
      4'd11: cga_default = 24'h55FFFF;
      4'd12: cga_default = 24'hFF5555;
      4'd13: cga_default = 24'hFF55FF;
      4'd14: cga_default = 24'hFFFF55;
      default: cga_default = 24'hFFFFFF;
    endcase
  endfunction

  logic [15:0][23:0] pal;
  pix_t              s1;
  wr_req_t           req;
  state_t            state, state_nxt;
  logic              accept, commit;
  // Set for the cycle right after a commit. It holds wr_ready low for one extra
  // cycle, so a write occupies two clocks from acceptance to the next ready.
  logic              cool;

  // ---------------- write FSM ----------------
  assign wr_ready = (state == IDLE) && !cool;
  assign busy     = (state == PEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        // A defaults_load in the same cycle blocks acceptance.
        if (wr_valid && wr_ready && !defaults_load) begin
          accept    = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (!COMMIT_IN_BLANK || !pix_de) begin
          commit    = !defaults_load;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // defaults_load discards any pending write.
    if (defaults_load) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req  <= '0;
      cool <= 1'b0;
    end else begin
      cool <= commit;
      if (accept) req <= '{addr: wr_addr, data: wr_data};
    end
  end

  // ---------------- palette table ----------------
  // Register-based table. A lookup in the same cycle as a commit or a
  // defaults_load reads the old value. The new contents are visible from the
  // next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) pal[i] <= cga_default(4'(i));
    end else if (defaults_load) begin
      for (int i = 0; i < 16; i++) pal[i] <= cga_default(4'(i));
    end else if (commit) begin
      pal[req.addr] <= req.data;
    end
  end

  // ---------------- pixel pipeline ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      rgb    <= '0;
      rgb_de <= 1'b0;
      rgb_hs <= 1'b0;
      rgb_vs <= 1'b0;
    end else begin
      s1     <= '{idx: pix_index, de: pix_de, hs: pix_hs, vs: pix_vs};
      // Blanking is applied at the register, so rgb is 0 for every cycle in
      // which rgb_de is 0.
      rgb    <= (BLANK_RGB_ZERO && !s1.de) ? 24'h0 : pal[s1.idx];
      rgb_de <= s1.de;
      rgb_hs <= s1.hs;
      rgb_vs <= s1.vs;
    end
  end

`ifdef PALETTE_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= pal[rd_addr];
  end
`endif

endmodule

// File: tb/tb_palette_ctrl.sv
// tb_palette_ctrl - self-checking bench for palette_ctrl (default parameters).
// Pixel expectations go through a scoreboard queue. Each cycle pushes one
// pixel, and the entry driven two cycles earlier is compared after the edge.
// An entry carries a fixed expected colour, or it takes the colour from the
// bench's palette model at compare time. The model is updated right after the
// edge on which a commit is expected, so it holds the table a lookup at the
// following edge must see.
`timescale 1ns/1ps
module tb_palette_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  pix_index = '0;
  logic        pix_de = 1'b0, pix_hs = 1'b0, pix_vs = 1'b0;
  logic [23:0] rgb;
  logic        rgb_de, rgb_hs, rgb_vs;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [3:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        defaults_load = 1'b0;
  logic        busy;
`ifdef PALETTE_READBACK_EN
  logic [3:0]  rd_addr = '0;
  logic [23:0] rd_data;
`endif

  always #5 clk = ~clk;

  palette_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .pix_index(pix_index), .pix_de(pix_de), .pix_hs(pix_hs), .pix_vs(pix_vs),
    .rgb(rgb), .rgb_de(rgb_de), .rgb_hs(rgb_hs), .rgb_vs(rgb_vs),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .defaults_load(defaults_load), .busy(busy)
`ifdef PALETTE_READBACK_EN
    , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
  );

  typedef struct {
    logic [3:0]  idx;
    logic        de, hs, vs;
    bit          fixed;
    logic [23:0] exp;
  } pe_t;

  pe_t         q[$];
  logic [23:0] mdl[16];
  int          total = 0;
  int          bad   = 0;

  function automatic logic [23:0] cga_ref(input int i);
    logic [23:0] t[16];
    t = '{24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
          24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
          24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
          24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};
    return t[i];
  endfunction

  task automatic mdl_defaults();
    for (int i = 0; i < 16; i++) mdl[i] = cga_ref(i);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one pixel for one cycle, then compare the pixel driven 2 cycles ago.
  task automatic cyc(input logic [3:0] idx, input logic de, input logic hs,
                     input logic vs, input bit fixed = 1'b0,
                     input logic [23:0] exp = 24'h0);
    pe_t         e;
    logic [23:0] er;
    pix_index = idx; pix_de = de; pix_hs = hs; pix_vs = vs;
    q.push_back('{idx, de, hs, vs, fixed, exp});
    @(posedge clk); #1;
    if (q.size() == 2) begin
      e  = q.pop_front();
      er = e.fixed ? e.exp : (e.de ? mdl[e.idx] : 24'h0);
      chk("rgb", {8'h0, rgb}, {8'h0, er});
      chk("sync", {29'h0, rgb_de, rgb_hs, rgb_vs}, {29'h0, e.de, e.hs, e.vs});
    end
  endtask

  typedef struct {
    logic [3:0]  idx;
    logic        de, hs, vs;
    logic [23:0] exp;
  } vec_t;

  vec_t vt[20];

  initial begin
    mdl_defaults();
    for (int i = 0; i < 16; i++)
      vt[i] = '{4'(i), 1'b1, 1'(i % 2), 1'(i == 15), cga_ref(i)};
    vt[16] = '{4'd7,  1'b0, 1'b1, 1'b0, 24'h0};
    vt[17] = '{4'd15, 1'b0, 1'b0, 1'b1, 24'h0};
    vt[18] = '{4'd9,  1'b0, 1'b1, 1'b1, 24'h0};
    vt[19] = '{4'd12, 1'b1, 1'b0, 1'b0, 24'hFF5555};

    // reset state
    #12;
    chk("rst_rgb", {8'h0, rgb}, 32'h0);
    chk("rst_sync", {29'h0, rgb_de, rgb_hs, rgb_vs}, 32'h0);
    chk("rst_wr_ready", {31'h0, wr_ready}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // table sweep of the CGA defaults
    for (int i = 0; i < 20; i++)
      cyc(vt[i].idx, vt[i].de, vt[i].hs, vt[i].vs, 1'b1, vt[i].exp);

    // write during blanking: busy 1 clk, wr_ready low 2 clks
    wr_valid = 1'b1; wr_addr = 4'd4; wr_data = 24'h123456;
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    chk("blank_busy_acc", {31'h0, busy}, 32'h1);
    chk("blank_rdy_acc", {31'h0, wr_ready}, 32'h0);
    wr_valid = 1'b0; wr_addr = 4'd9; wr_data = 24'h0;
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    mdl[4] = 24'h123456;
    chk("blank_busy_cmt", {31'h0, busy}, 32'h0);
    chk("blank_rdy_cmt", {31'h0, wr_ready}, 32'h0);
    cyc(4'd0, 1'b0, 1'b1, 1'b0);
    chk("blank_rdy_back", {31'h0, wr_ready}, 32'h1);
    cyc(4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 24'h123456);
    cyc(4'd3, 1'b1, 1'b0, 1'b0);
    cyc(4'd4, 1'b1, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);

    // write during an active run: held until the first blank cycle
    wr_valid = 1'b1; wr_addr = 4'd1; wr_data = 24'hFF0000;
    cyc(4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0000AA);
    wr_valid = 1'b0;
    chk("run_busy_acc", {31'h0, busy}, 32'h1);
    for (int i = 0; i < 9; i++) cyc(4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0000AA);
    chk("run_busy_hold", {31'h0, busy}, 32'h1);
    chk("run_rdy_hold", {31'h0, wr_ready}, 32'h0);
    cyc(4'd1, 1'b0, 1'b0, 1'b0);
    mdl[1] = 24'hFF0000;
    chk("run_busy_cmt", {31'h0, busy}, 32'h0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    cyc(4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 24'hFF0000);
    cyc(4'd1, 1'b1, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);

    // pending write discarded by defaults_load
    wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 24'h123123;
    cyc(4'd2, 1'b1, 1'b0, 1'b0);
    wr_valid = 1'b0;
    chk("dl_busy_acc", {31'h0, busy}, 32'h1);
    cyc(4'd2, 1'b1, 1'b0, 1'b0);
    defaults_load = 1'b1;
    cyc(4'd2, 1'b1, 1'b0, 1'b0);
    defaults_load = 1'b0;
    mdl_defaults();
    chk("dl_busy_clr", {31'h0, busy}, 32'h0);
    chk("dl_rdy", {31'h0, wr_ready}, 32'h1);
    // a write offered together with defaults_load is refused
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 24'h111111; defaults_load = 1'b1;
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    wr_valid = 1'b0; defaults_load = 1'b0;
    chk("dl_no_accept", {31'h0, busy}, 32'h0);
    cyc(4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 24'h00AA00);
    cyc(4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0000AA);
    cyc(4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 24'hAA0000);
    cyc(4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 24'hAA00AA);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);

`ifdef PALETTE_READBACK_EN
    // readback: old value on the commit edge, new value one cycle later
    wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 24'hABCDEF; rd_addr = 4'd7;
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    wr_valid = 1'b0;
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    mdl[7] = 24'hABCDEF;
    chk("rd_old", {8'h0, rd_data}, 32'h00AAAAAA);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    chk("rd_new", {8'h0, rd_data}, 32'h00ABCDEF);
    cyc(4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 24'hABCDEF);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
`endif

    // reset mid-frame after writing idx15, with a second write pending
    wr_valid = 1'b1; wr_addr = 4'd15; wr_data = 24'h000001;
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    wr_valid = 1'b0;
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    mdl[15] = 24'h000001;
    cyc(4'd15, 1'b1, 1'b0, 1'b0);
    cyc(4'd15, 1'b1, 1'b1, 1'b0);
    wr_valid = 1'b1; wr_addr = 4'd15; wr_data = 24'h222222;
    cyc(4'd15, 1'b1, 1'b0, 1'b1);
    wr_valid = 1'b0;
    chk("mid_busy", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rgb", {8'h0, rgb}, 32'h0);
    chk("arst_sync", {29'h0, rgb_de, rgb_hs, rgb_vs}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_rdy", {31'h0, wr_ready}, 32'h1);
    q.delete();
    mdl_defaults();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(4'd15, 1'b1, 1'b0, 1'b0, 1'b1, 24'hFFFFFF);
    cyc(4'd15, 1'b1, 1'b1, 1'b0, 1'b1, 24'hFFFFFF);
    cyc(4'd15, 1'b1, 1'b0, 1'b0, 1'b1, 24'hFFFFFF);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    chk("post_busy", {31'h0, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
